// File: rtl/sorted_stream_tx.sv
// Buffers whole sorted vectors in a small FIFO and streams them out one element per handshake.
// Vectors that arrive while the buffer is full (and nothing pops) are dropped and flagged.
module sorted_stream_tx #(
    parameter int unsigned NUMBER_WIDTH   = 10,
    parameter int unsigned NUMBERS_AMOUNT = 10,
    parameter int unsigned BUF_DEPTH      = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
    input  logic                                         data_valid_i,
    output logic [NUMBER_WIDTH-1:0]                      data_o,
    output logic                                         valid_o,
    input  logic                                         ready_i,
    output logic                                         last_o,
    output logic [$clog2(NUMBERS_AMOUNT)-1:0]            index_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0]               vec_count_o,
    output logic                                         overflow_o
);

    localparam int unsigned IdxW = $clog2(NUMBERS_AMOUNT);
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;

    vec_t            mem_q [BUF_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            overflow_q, overflow_d;

    logic not_empty;
    logic full;
    logic at_last;
    logic handshake;
    logic pop;
    logic wr_en;
    logic drop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == CntW'(BUF_DEPTH));
        at_last   = (idx_q == IdxW'(NUMBERS_AMOUNT - 1));
        handshake = not_empty & ready_i;
        pop       = handshake & at_last;
        // A full buffer can still take a vector on the cycle its head pops.
        wr_en     = data_valid_i & (~full | pop);
        drop      = data_valid_i & full & ~pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | drop;

        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (handshake) begin
            if (at_last) begin
                idx_d    = '0;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
        if (wr_en && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; the count alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        valid_o     = not_empty;
        last_o      = not_empty & at_last;
        index_o     = idx_q;
        data_o      = mem_q[rd_ptr_q][idx_q];
        vec_count_o = count_q;
        overflow_o  = overflow_q;
    end

endmodule

// File: tb/tb_sorted_stream_tx.sv
// Scoreboard bench for sorted_stream_tx: stimulus pushes expected elements, a monitor checks them.
module tb_sorted_stream_tx;

    localparam int unsigned NW = 10;
    localparam int unsigned NA = 10;
    localparam int unsigned BD = 2;

    typedef struct packed {
        logic [NW-1:0] d;
        logic [3:0]    i;
        logic          l;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NA-1:0][NW-1:0]  data_i = '0;
    logic                   data_valid_i = 1'b0;
    logic                   ready_i = 1'b0;
    logic [NW-1:0]          data_o;
    logic                   valid_o;
    logic                   last_o;
    logic [3:0]             index_o;
    logic [1:0]             vec_count_o;
    logic                   overflow_o;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    sorted_stream_tx #(
        .NUMBER_WIDTH  (NW),
        .NUMBERS_AMOUNT(NA),
        .BUF_DEPTH     (BD)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .index_o     (index_o),
        .vec_count_o (vec_count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one vector (element i = base+i) for a single cycle; call at posedge+1.
    task automatic issue(input int base, input bit accepted);
        for (int i = 0; i < int'(NA); i++) begin
            data_i[i] = NW'(base + i);
            if (accepted) begin
                sb.push_back('{d: NW'(base + i), i: 4'(i), l: (i == int'(NA) - 1)});
            end
        end
        data_valid_i = 1'b1;
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: peeks the head while valid (so held data is checked), pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got data 0x%0h idx %0d, expected none",
                             data_o, index_o);
                end else begin
                    check("stream_data", 32'(data_o), 32'(sb[0].d));
                    check("stream_index", 32'(index_o), 32'(sb[0].i));
                    check("stream_last", 32'(last_o), 32'(sb[0].l));
                    if (ready_i) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   vrec[40];
        bit   lrec[40];
        int   first;
        int   run;
        int   total;
        bit   found;
        logic [39:0] lmask_act;
        logic [39:0] lmask_exp;

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_index", 32'(index_o), 32'd0);
        check("rst_count", 32'(vec_count_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single vector, accepted on the first edge after release, latency 1.
        ready_i = 1'b1;
        issue(0, 1'b1);
        check("single_latency_valid", 32'(valid_o), 32'd1);
        check("single_count", 32'(vec_count_o), 32'd1);
        wait_drain();
        check("single_count_end", 32'(vec_count_o), 32'd0);
        check("single_valid_end", 32'(valid_o), 32'd0);

        // Backpressure: ready toggles every cycle.
        ready_i = 1'b0;
        issue(0, 1'b1);
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            ready_i = (c % 2 == 0);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        wait_drain();
        check("bp_count_end", 32'(vec_count_o), 32'd0);

        // Overflow: third vector into a full buffer is dropped.
        ready_i = 1'b0;
        issue(30, 1'b1);
        issue(40, 1'b1);
        check("ovf_not_yet", 32'(overflow_o), 32'd0);
        check("ovf_count_full", 32'(vec_count_o), 32'd2);
        issue(50, 1'b0);
        check("ovf_count", 32'(vec_count_o), 32'd2);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        ready_i = 1'b1;
        wait_drain();
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        check("ovf_count_end", 32'(vec_count_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("ovf_cleared", 32'(overflow_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full buffer with a write on the same cycle the head pops.
        ready_i = 1'b0;
        issue(60, 1'b1);
        issue(70, 1'b1);
        check("fullpop_count_pre", 32'(vec_count_o), 32'd2);
        ready_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (index_o == 4'd9 && vec_count_o == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("fullpop_reach_last", 32'(found), 32'd1);
        issue(80, 1'b1);
        check("fullpop_count", 32'(vec_count_o), 32'd2);
        check("fullpop_overflow", 32'(overflow_o), 32'd0);
        wait_drain();
        check("fullpop_count_end", 32'(vec_count_o), 32'd0);

        // Back-to-back vectors: 20 contiguous valid cycles, last at 10th and 20th.
        ready_i = 1'b1;
        fork
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    vrec[c] = valid_o;
                    lrec[c] = last_o;
                end
            end
            begin
                issue(10, 1'b1);
                issue(20, 1'b1);
            end
        join
        first = -1;
        total = 0;
        run = 0;
        lmask_act = '0;
        for (int c = 0; c < 30; c++) begin
            if (vrec[c]) total++;
            if (vrec[c] && first < 0) first = c;
            lmask_act[c] = lrec[c];
        end
        if (first >= 0) begin
            for (int c = first; c < 30 && vrec[c]; c++) run++;
        end
        lmask_exp = '0;
        if (first >= 0) begin
            lmask_exp[first + 9]  = 1'b1;
            lmask_exp[first + 19] = 1'b1;
        end
        check("b2b_first", 32'(first), 32'd1);
        check("b2b_total", 32'(total), 32'd20);
        check("b2b_contiguous", 32'(run), 32'd20);
        check("b2b_last_pos", lmask_act[31:0], lmask_exp[31:0]);
        wait_drain();

        // Reset in the middle of a vector.
        issue(90, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (index_o == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("midrst_reach_idx4", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_index", 32'(index_o), 32'd0);
        check("midrst_last", 32'(last_o), 32'd0);
        check("midrst_count", 32'(vec_count_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_idle_valid", 32'(valid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(0, 1'b1);
        wait_drain();
        check("midrst_final_count", 32'(vec_count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
